// File: rtl/multicycle_main_control_pkg.sv
// Shared constants for the multicycle Mini-MIPS control FSM: state codes,
// opcode map, ALUop encodings, mux selects and the control bundle type.
package mc_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_FETCH    = 4'd1;
    localparam state_t ST_DECODE   = 4'd2;
    localparam state_t ST_EXEC_R   = 4'd3;
    localparam state_t ST_EXEC_I   = 4'd4;
    localparam state_t ST_ALU_WB   = 4'd5;
    localparam state_t ST_MEM_ADDR = 4'd6;
    localparam state_t ST_MEM_RD   = 4'd7;
    localparam state_t ST_MEM_WB   = 4'd8;
    localparam state_t ST_MEM_WR   = 4'd9;
    localparam state_t ST_BRANCH   = 4'd10;

    localparam int unsigned OP_RTYPE = 0;
    localparam int unsigned OP_ADDI  = 1;
    localparam int unsigned OP_ANDI  = 2;
    localparam int unsigned OP_ORI   = 3;
    localparam int unsigned OP_NORI  = 4;
    localparam int unsigned OP_SLTI  = 5;
    localparam int unsigned OP_LW    = 6;
    localparam int unsigned OP_SW    = 7;
    localparam int unsigned OP_BEQ   = 8;
    localparam int unsigned OP_BNE   = 9;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_NOR   = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_FUNCT = 3'b110;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic       branch_ne;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
        logic       mem_timeout;
    } ctrl_t;

    // ALU operation for the immediate-form arithmetic/logic instructions.
    function automatic logic [2:0] imm_alu_op(input logic [31:0] op);
        logic [2:0] r;
        r = ALU_ADD;
        case (op)
            OP_ANDI: r = ALU_AND;
            OP_ORI:  r = ALU_OR;
            OP_NORI: r = ALU_NOR;
            OP_SLTI: r = ALU_SLT;
            default: r = ALU_ADD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multicycle_main_control_if.sv
// Control bus between the multicycle controller (master) and the datapath /
// instruction register / memory side (slave).
interface multicycle_main_control_if #(
    parameter int OPCODE_W = 4,
    parameter int ALUOP_W  = 3
);
    logic                en;
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;

    logic                PCWrite;
    logic                PCWriteCond;
    logic                IorD;
    logic                IRWrite;
    logic                MemRead;
    logic                MemWrite;
    logic                MemtoReg;
    logic                RegDst;
    logic                RegWrite;
    logic                ALUSrcA;
    logic                BranchNe;
    logic [1:0]          ALUSrcB;
    logic [1:0]          PCSource;
    logic [ALUOP_W-1:0]  ALUop;
    logic                instr_done;
    logic                illegal_op;
    logic                mem_timeout;

    modport master (
        input  en, opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, BranchNe, ALUSrcB,
               PCSource, ALUop, instr_done, illegal_op, mem_timeout
    );

    modport slave (
        output en, opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, BranchNe, ALUSrcB,
               PCSource, ALUop, instr_done, illegal_op, mem_timeout
    );
endinterface

// File: rtl/multicycle_main_control_wait_timer.sv
// Memory wait counter: counts stalled cycles and flags the cycle on which
// the wait budget is exhausted.
module mc_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic waiting,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (waiting && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = waiting && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle control FSM for the Mini-MIPS shared-ALU/shared-memory datapath.
//
// state    | meaning
// IDLE     | halted, all controls low, waits for en
// FETCH    | read instruction, PC += 1 when memory answers
// DECODE   | latch opcode, precompute branch target
// EXEC_R   | register-register ALU operation
// EXEC_I   | register-immediate ALU operation
// ALU_WB   | write ALU result to register file
// MEM_ADDR | compute load/store address
// MEM_RD   | load data read, stalls on mem_ready
// MEM_WB   | write loaded data to register file
// MEM_WR   | store data write, stalls on mem_ready
// BRANCH   | compare and conditionally update PC
module multicycle_main_control
    import mc_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int ALUOP_W  = 3,
    parameter int TIMEOUT  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multicycle_main_control_if.master bus
);

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    ctrl_t               ctl;
    logic                in_wait_state;
    logic                waiting;
    logic                expired;
    logic                state_chg;
    logic [31:0]         opc_now;
    logic [31:0]         opc_lat;

    assign opc_now = 32'(bus.opcode);
    assign opc_lat = 32'(op_q);

    assign in_wait_state = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) ||
                           (state_q == ST_MEM_WR);
    assign waiting   = in_wait_state && !bus.mem_ready;
    assign state_chg = (state_d != state_q);

    mc_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_chg),
        .waiting (waiting),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ctl     = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.en) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = SRCB_ONE;
                ctl.alu_op    = ALU_ADD;
                ctl.pc_source = PCSRC_ALU;
                ctl.ir_write  = bus.mem_ready;
                ctl.pc_write  = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = ST_DECODE;
                end else if (expired) begin
                    ctl.mem_timeout = 1'b1;
                    state_d         = ST_IDLE;
                end
            end
            ST_DECODE: begin
                ctl.alu_src_b = SRCB_BOFS;
                ctl.alu_op    = ALU_ADD;
                op_d          = bus.opcode;
                case (opc_now)
                    OP_RTYPE:                                  state_d = ST_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_NORI, OP_SLTI: state_d = ST_EXEC_I;
                    OP_LW, OP_SW:                              state_d = ST_MEM_ADDR;
                    OP_BEQ, OP_BNE:                            state_d = ST_BRANCH;
                    default: begin
                        ctl.illegal_op = 1'b1;
                        ctl.instr_done = 1'b1;
                    end
                endcase
            end
            ST_EXEC_R: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_REG;
                ctl.alu_op    = ALU_FUNCT;
                state_d       = ST_ALU_WB;
            end
            ST_EXEC_I: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = imm_alu_op(opc_lat);
                state_d       = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = (opc_lat == OP_RTYPE);
                ctl.instr_done = 1'b1;
            end
            ST_MEM_ADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALU_ADD;
                state_d       = (opc_lat == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
                if (bus.mem_ready) begin
                    state_d = ST_MEM_WB;
                end else if (expired) begin
                    ctl.mem_timeout = 1'b1;
                    state_d         = ST_IDLE;
                end
            end
            ST_MEM_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                ctl.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                ctl.mem_write = 1'b1;
                ctl.i_or_d    = 1'b1;
                if (bus.mem_ready) begin
                    ctl.instr_done = 1'b1;
                end else if (expired) begin
                    ctl.mem_timeout = 1'b1;
                    state_d         = ST_IDLE;
                end
            end
            ST_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_src_b     = SRCB_REG;
                ctl.alu_op        = ALU_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = PCSRC_ALUOUT;
                ctl.branch_ne     = (opc_lat == OP_BNE);
                ctl.instr_done    = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // en is only honoured at instruction boundaries
        if (ctl.instr_done) begin
            state_d = bus.en ? ST_FETCH : ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    assign bus.PCWrite     = ctl.pc_write;
    assign bus.PCWriteCond = ctl.pc_write_cond;
    assign bus.IorD        = ctl.i_or_d;
    assign bus.IRWrite     = ctl.ir_write;
    assign bus.MemRead     = ctl.mem_read;
    assign bus.MemWrite    = ctl.mem_write;
    assign bus.MemtoReg    = ctl.mem_to_reg;
    assign bus.RegDst      = ctl.reg_dst;
    assign bus.RegWrite    = ctl.reg_write;
    assign bus.ALUSrcA     = ctl.alu_src_a;
    assign bus.BranchNe    = ctl.branch_ne;
    assign bus.ALUSrcB     = ctl.alu_src_b;
    assign bus.PCSource    = ctl.pc_source;
    assign bus.ALUop       = ALUOP_W'(ctl.alu_op);
    assign bus.instr_done  = ctl.instr_done;
    assign bus.illegal_op  = ctl.illegal_op;
    assign bus.mem_timeout = ctl.mem_timeout;

endmodule
